// File: rtl/ps2_tx_if.sv
// Command handshake between a client and the PS/2 host transmitter.
interface ps2_tx_if;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (output tx_req, tx_data, input tx_busy, tx_done, tx_err);
  modport slave  (input tx_req, tx_data, output tx_busy, tx_done, tx_err);
endinterface

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity + stop, device ack.
// Optional macro PS2_TX_RESEND_EN: one automatic retransmission of the latched byte after a NACK.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic    clk,
  input  logic    rst,
  ps2_tx_if.slave bus,
  input  logic    ps2_clk_in,
  input  logic    ps2_data_in,
  output logic    ps2_clk_oe,
  output logic    ps2_data_oe
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          clk_prev_q, clk_prev_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    edge_q, edge_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          clk_s, data_s, fall, nack, fail;
`ifdef PS2_TX_RESEND_EN
  logic          retry_q, retry_d;
`endif

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_prev_q & ~clk_s;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_prev_d  = clk_s;
    state_d     = state_q;
    shift_d     = shift_q;
    edge_d      = edge_q;
    cnt_d       = cnt_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    nack        = 1'b0;
    fail        = 1'b0;
`ifdef PS2_TX_RESEND_EN
    retry_d     = retry_q;
`endif
    // Timeout counter runs from clock release to ack and saturates.
    if (state_q inside {RTS, SHIFT, ACK, WAIT_IDLE} && cnt_q != TO_LAST)
      cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.tx_req) begin
          state_d  = INHIBIT;
          shift_d  = {~^bus.tx_data, bus.tx_data};
          edge_d   = 4'd0;
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          busy_d   = 1'b1;
`ifdef PS2_TX_RESEND_EN
          retry_d  = 1'b0;
`endif
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d   = RTS;
          cnt_d     = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RTS: begin
        if (fall) begin
          state_d   = SHIFT;
          edge_d    = 4'd1;
          data_oe_d = ~shift_q[0];
        end
      end
      SHIFT: begin
        if (fall) begin
          edge_d = edge_q + 4'd1;
          if (edge_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            data_oe_d = ~shift_q[edge_q];
          end
        end
      end
      ACK: begin
        if (fall) begin
          edge_d = 4'd11;
          if (!data_s) state_d = WAIT_IDLE;
          else         nack    = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (nack) begin
`ifdef PS2_TX_RESEND_EN
      if (!retry_q) begin
        retry_d   = 1'b1;
        state_d   = INHIBIT;
        cnt_d     = '0;
        edge_d    = 4'd0;
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
      end else begin
        fail = 1'b1;
      end
`else
      fail = 1'b1;
`endif
    end
    if (state_q inside {RTS, SHIFT, ACK, WAIT_IDLE} && cnt_q == TO_LAST) fail = 1'b1;

    if (fail) begin
      state_d   = IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      shift_q     <= '0;
      edge_q      <= '0;
      cnt_q       <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      shift_q     <= shift_d;
      edge_q      <= edge_d;
      cnt_q       <= cnt_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

`ifdef PS2_TX_RESEND_EN
  always_ff @(posedge clk) begin
    if (!rst) retry_q <= 1'b0;
    else      retry_q <= retry_d;
  end
`endif

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;
  assign bus.tx_err  = err_q;
endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: open-drain bus with a behavioural PS/2 device, frame model and per-cycle invariants.
module tb_ps2_tx;
  localparam int INH  = 8;
  localparam int TO   = 4000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ps2_tx_if bus();
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_line, data_line;
  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ps2_clk_in(clk_line), .ps2_data_in(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, acc_cnt = 0, inh_runs = 0, inh_len = 0, last_inh = 0;
  logic prev_busy = 1'b0, prev_clk_oe = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame as the device sees it at rising edges 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    int ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(b[k]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  always @(negedge clk) begin
    chk_eq("pulse_exclusive", int'(bus.tx_done && bus.tx_err), 0);
    if (bus.tx_done || bus.tx_err) chk_eq("busy_in_pulse", int'(bus.tx_busy), 0);
    if (!bus.tx_busy) chk_eq("oe_while_idle", int'(ps2_clk_oe || ps2_data_oe), 0);
    if (ps2_clk_oe) chk_eq("data_oe_in_inhibit", int'(ps2_data_oe), 0);
    if (bus.tx_done) chk_eq("done_one_cycle", int'(prev_done), 0);
    if (bus.tx_err) chk_eq("err_one_cycle", int'(prev_err), 0);
    if (bus.tx_done) done_cnt++;
    if (bus.tx_err) err_cnt++;
    if (bus.tx_busy && !prev_busy) acc_cnt++;
    if (ps2_clk_oe) inh_len++;
    if (!ps2_clk_oe && prev_clk_oe) begin
      last_inh = inh_len;
      inh_runs++;
      inh_len = 0;
    end
    prev_busy   = bus.tx_busy;
    prev_clk_oe = ps2_clk_oe;
    prev_done   = bus.tx_done;
    prev_err    = bus.tx_err;
  end

  task automatic send(input logic [7:0] d);
    bus.tx_data = d;
    bus.tx_req  = 1'b1;
    @(negedge clk);
    bus.tx_req  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.tx_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk_eq("idle_timeout", n, 0);
    repeat (3) @(negedge clk);
  endtask

  // Device: waits for request-to-send, clocks 11 bits, acks unless nack; rst_at>0 resets the host
  // half-way through the low phase of that clock.
  task automatic dev_frame(input bit nack, input int rst_at, output logic [9:0] samp);
    int n = 0;
    samp = '0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      chk_eq("rts_timeout", n, 0);
      return;
    end
    chk_eq("start_bit", int'(data_line), 0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      dev_clk_low = 1'b1;
      if (i + 1 == rst_at) begin
        repeat (10) @(negedge clk);
        chk_eq("busy_before_rst", int'(bus.tx_busy), 1);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_clk_oe", int'(ps2_clk_oe), 0);
        chk_eq("rst_data_oe", int'(ps2_data_oe), 0);
        chk_eq("rst_busy", int'(bus.tx_busy), 0);
        rst = 1'b1;
        repeat (HALF - 11) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk_low = 1'b0;
      if (i < 10) samp[i] = data_line;
      if (i == 9 && !nack) begin
        repeat (HALF / 2) @(negedge clk);
        dev_data_low = 1'b1;
        repeat (HALF / 2) @(negedge clk);
      end else if (i == 10) begin
        repeat (5) @(negedge clk);
        dev_data_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [9:0] s1, s2;
    int d0, e0, r0, a0, n;
    bus.tx_req  = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_eq("reset_clk_oe", int'(ps2_clk_oe), 0);
    chk_eq("reset_data_oe", int'(ps2_data_oe), 0);
    chk_eq("reset_busy", int'(bus.tx_busy), 0);
    chk_eq("reset_done", int'(bus.tx_done), 0);
    chk_eq("reset_err", int'(bus.tx_err), 0);
    rst = 1'b1;
    @(negedge clk);

    chk_eq("model_ed", int'(exp_frame(8'hED)), 'h3ED);
    chk_eq("model_00", int'(exp_frame(8'h00)), 'h300);
    chk_eq("model_01", int'(exp_frame(8'h01)), 'h201);

    // 8'hED with ack
    d0 = done_cnt; e0 = err_cnt; r0 = inh_runs;
    send(8'hED);
    dev_frame(1'b0, 0, s1);
    wait_idle();
    chk_eq("ed_bits", int'(s1), 'h3ED);
    chk_eq("ed_model", int'(s1), int'(exp_frame(8'hED)));
    chk_eq("ed_done", done_cnt - d0, 1);
    chk_eq("ed_err", err_cnt - e0, 0);
    chk_eq("ed_frames", inh_runs - r0, 1);
    chk_eq("ed_inhibit_len", last_inh, INH);

    // parity boundaries
    send(8'h00);
    dev_frame(1'b0, 0, s1);
    wait_idle();
    chk_eq("p00_bits", int'(s1), int'(exp_frame(8'h00)));
    chk_eq("p00_parity", int'(s1[8]), 1);
    chk_eq("p00_inhibit_len", last_inh, INH);
    send(8'h01);
    dev_frame(1'b0, 0, s1);
    wait_idle();
    chk_eq("p01_bits", int'(s1), int'(exp_frame(8'h01)));
    chk_eq("p01_parity", int'(s1[8]), 0);
    chk_eq("p01_inhibit_len", last_inh, INH);

    // device never clocks: error exactly TO cycles after release
    e0 = err_cnt; d0 = done_cnt;
    send(8'h3C);
    n = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq("to_rts_seen", int'(n < 100), 1);
    n = 0;
    while (!bus.tx_err && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq("to_latency", n, TO);
    chk_eq("to_clk_oe", int'(ps2_clk_oe), 0);
    chk_eq("to_data_oe", int'(ps2_data_oe), 0);
    chk_eq("to_busy", int'(bus.tx_busy), 0);
    repeat (3) @(negedge clk);
    chk_eq("to_err_cnt", err_cnt - e0, 1);
    chk_eq("to_done_cnt", done_cnt - d0, 0);

    // NACK once then ACK
    d0 = done_cnt; e0 = err_cnt; r0 = inh_runs;
    send(8'hA5);
    dev_frame(1'b1, 0, s1);
    chk_eq("nack_bits1", int'(s1), int'(exp_frame(8'hA5)));
`ifdef PS2_TX_RESEND_EN
    dev_frame(1'b0, 0, s2);
    wait_idle();
    chk_eq("resend_bits2", int'(s2), int'(exp_frame(8'hA5)));
    chk_eq("resend_done", done_cnt - d0, 1);
    chk_eq("resend_err", err_cnt - e0, 0);
    chk_eq("resend_frames", inh_runs - r0, 2);
`else
    wait_idle();
    chk_eq("nack_done", done_cnt - d0, 0);
    chk_eq("nack_err", err_cnt - e0, 1);
    chk_eq("nack_frames", inh_runs - r0, 1);
`endif

    // reset after edge 5 of 8'hF4, then a normal 8'hFF
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    dev_frame(1'b0, 5, s1);
    repeat (5) @(negedge clk);
    chk_eq("rst_no_done", done_cnt - d0, 0);
    chk_eq("rst_no_err", err_cnt - e0, 0);
    send(8'hFF);
    dev_frame(1'b0, 0, s1);
    wait_idle();
    chk_eq("ff_bits", int'(s1), 'h3FF);
    chk_eq("ff_done", done_cnt - d0, 1);
    chk_eq("ff_err", err_cnt - e0, 0);

    // held request: 8'h55 appears after acceptance of 8'hED
    d0 = done_cnt; a0 = acc_cnt; r0 = inh_runs;
    bus.tx_data = 8'hED;
    bus.tx_req  = 1'b1;
    @(negedge clk);
    bus.tx_data = 8'h55;
    dev_frame(1'b0, 0, s1);
    bus.tx_req = 1'b0;
    chk_eq("hold_first_bits", int'(s1), 'h3ED);
    chk_eq("hold_first_done", done_cnt - d0, 1);
    chk_eq("hold_reaccept", acc_cnt - a0, 2);
    dev_frame(1'b0, 0, s2);
    wait_idle();
    chk_eq("hold_second_bits", int'(s2), 'h355);
    chk_eq("hold_total_done", done_cnt - d0, 2);
    chk_eq("hold_total_accepts", acc_cnt - a0, 2);
    chk_eq("hold_total_frames", inh_runs - r0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
